// File: rtl/cmp_pkg.sv
// Shared types for the magnitude comparator family: FSM states, per-beat
// decision encoding and the cascade-input resolution used on an all-equal tie.
package cmp_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  typedef enum logic [1:0] {
    UNDECIDED,
    GT,
    LT
  } dec_t;

  // An all-equal tie defers to the lower-significance stage: eq > gt > lt,
  // and no asserted input at all is treated as equal.
  function automatic dec_t resolve_cascade(input logic aeqbin,
                                           input logic agtbin,
                                           input logic altbin);
    if (aeqbin)      return UNDECIDED;
    else if (agtbin) return GT;
    else if (altbin) return LT;
    else             return UNDECIDED;
  endfunction

endpackage

// File: rtl/cmp_slice.sv
// Combinational unsigned W-bit compare of one beat.
module cmp_slice #(
  parameter int unsigned W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         gt,
  output logic         lt
);

  assign gt = (a > b);
  assign lt = (a < b);

endmodule

// File: rtl/seq_mag_compare.sv
// Sequential multi-beat magnitude comparator: MSB beat first, first differing
// beat decides, an all-equal stream resolves from the cascade inputs latched at start.
module seq_mag_compare
  import cmp_pkg::*;
#(
  parameter int unsigned W      = 8,
  parameter int unsigned NBYTES = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         aeqbin,
  input  logic         agtbin,
  input  logic         altbin,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a_in,
  input  logic [W-1:0] b_in,
  output logic         aeqb,
  output logic         agtb,
  output logic         altb,
  output logic         done,
  output logic         busy
);

  localparam int unsigned CW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [CW-1:0] LAST = CW'(NBYTES - 1);

  state_t        state, state_n;
  dec_t          dec, dec_n, fin;
  logic [CW-1:0] cnt, cnt_n;
  logic [2:0]    casc, casc_n;
  logic          eq_n, gt_n, lt_n;
  logic          slice_gt, slice_lt;
  logic          accept;

  cmp_slice #(.W(W)) u_slice (
    .a  (a_in),
    .b  (b_in),
    .gt (slice_gt),
    .lt (slice_lt)
  );

  assign in_ready = (state == RUN);
  assign busy     = (state != IDLE);
  assign done     = (state == DONE);
  assign accept   = in_valid && in_ready;

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    dec_n   = dec;
    casc_n  = casc;
    eq_n    = aeqb;
    gt_n    = agtb;
    lt_n    = altb;
    fin     = UNDECIDED;
    case (state)
      IDLE: begin
        if (start) begin
          state_n = RUN;
          cnt_n   = '0;
          dec_n   = UNDECIDED;
          casc_n  = {aeqbin, agtbin, altbin};
        end
      end
      RUN: begin
        if (accept) begin
          if (dec == UNDECIDED) begin
            if (slice_gt)      dec_n = GT;
            else if (slice_lt) dec_n = LT;
          end
          cnt_n = cnt + CW'(1);
          // Results are loaded on the last-beat edge so they are valid
          // in the very cycle done is high; the last beat itself can decide.
          if (cnt == LAST) begin
            state_n = DONE;
            fin     = dec_n;
            if (fin == UNDECIDED) fin = resolve_cascade(casc[2], casc[1], casc[0]);
            eq_n    = (fin == UNDECIDED);
            gt_n    = (fin == GT);
            lt_n    = (fin == LT);
          end
        end
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      dec   <= UNDECIDED;
      casc  <= '0;
      aeqb  <= 1'b1;
      agtb  <= 1'b0;
      altb  <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      dec   <= dec_n;
      casc  <= casc_n;
      aeqb  <= eq_n;
      agtb  <= gt_n;
      altb  <= lt_n;
    end
  end

endmodule

// File: tb/tb_seq_mag_compare.sv
// Scoreboard bench for seq_mag_compare: one NBYTES=1 and one NBYTES=4 instance
// share the beat inputs; only the instance given a start pulse takes part.
module tb_seq_mag_compare;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start1 = 1'b0, start4 = 1'b0;
  logic       aeqbin = 1'b0, agtbin = 1'b0, altbin = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] a_in = '0, b_in = '0;

  logic rdy1, eq1, gt1, lt1, done1, busy1;
  logic rdy4, eq4, gt4, lt4, done4, busy4;

  bit         sel4 = 1'b0;
  logic       rdy, done_o, busy_o;
  logic [2:0] res_o;

  int checks = 0;
  int errors = 0;
  logic [2:0] exp_q[$];

  seq_mag_compare #(.W(8), .NBYTES(1)) u_dut1 (
    .clk(clk), .rst(rst), .start(start1),
    .aeqbin(aeqbin), .agtbin(agtbin), .altbin(altbin),
    .in_valid(in_valid), .in_ready(rdy1), .a_in(a_in), .b_in(b_in),
    .aeqb(eq1), .agtb(gt1), .altb(lt1), .done(done1), .busy(busy1)
  );

  seq_mag_compare #(.W(8), .NBYTES(4)) u_dut4 (
    .clk(clk), .rst(rst), .start(start4),
    .aeqbin(aeqbin), .agtbin(agtbin), .altbin(altbin),
    .in_valid(in_valid), .in_ready(rdy4), .a_in(a_in), .b_in(b_in),
    .aeqb(eq4), .agtb(gt4), .altb(lt4), .done(done4), .busy(busy4)
  );

  assign rdy    = sel4 ? rdy4  : rdy1;
  assign done_o = sel4 ? done4 : done1;
  assign busy_o = sel4 ? busy4 : busy1;
  assign res_o  = sel4 ? {eq4, gt4, lt4} : {eq1, gt1, lt1};

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Whole-operand reference: {eq, gt, lt}
  function automatic logic [2:0] model(input logic [31:0] a, input logic [31:0] b,
                                       input logic [2:0] casc);
    if (a > b)        return 3'b010;
    else if (a < b)   return 3'b001;
    else if (casc[2]) return 3'b100;
    else if (casc[1]) return 3'b010;
    else if (casc[0]) return 3'b001;
    else              return 3'b100;
  endfunction

  // Drives one comparison; vpat gives in_valid per offered cycle (1 past npat).
  task automatic run(input bit s4, input logic [31:0] a, input logic [31:0] b,
                     input logic [2:0] casc, input logic [7:0] vpat, input int npat,
                     input int mid_start, input int rst_after,
                     output int acc, output bit early, output bit run_ok,
                     output int lat, output logic [2:0] res);
    int nb, p, cyc;
    bit acc_now;
    logic [31:0] sa, sb;
    nb = s4 ? 4 : 1;
    sel4 = s4;
    acc = 0; early = 1'b0; lat = -1; res = 3'b000; p = 0; cyc = 0;
    {aeqbin, agtbin, altbin} = casc;
    if (s4) start4 = 1'b1; else start1 = 1'b1;
    step();
    start1 = 1'b0; start4 = 1'b0;
    {aeqbin, agtbin, altbin} = 3'b000;
    run_ok = busy_o && rdy;
    while (acc < nb && cyc < 40) begin
      in_valid = (p < npat) ? vpat[p] : 1'b1;
      p++;
      sa = a >> (8 * (nb - 1 - acc));
      sb = b >> (8 * (nb - 1 - acc));
      a_in = sa[7:0];
      b_in = sb[7:0];
      if (cyc == mid_start) begin
        if (s4) start4 = 1'b1; else start1 = 1'b1;
      end
      acc_now = in_valid && rdy;
      step();
      cyc++;
      start1 = 1'b0; start4 = 1'b0;
      if (acc_now) acc++;
      if (acc < nb && done_o) early = 1'b1;
      if (rst_after >= 0 && acc == rst_after) begin
        in_valid = 1'b0;
        return;
      end
    end
    in_valid = 1'b0;
    if (acc == nb) begin
      for (int i = 1; i <= 5; i++) begin
        if (done_o) begin
          lat = i;
          res = res_o;
          break;
        end
        step();
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    checks++;
    if ({rdy1, done1, busy1, eq1, gt1, lt1} !== 6'b000100) begin
      errors++;
      $display("FAIL reset_dut1 got rdy/done/busy/eq/gt/lt=%b want 000100",
               {rdy1, done1, busy1, eq1, gt1, lt1});
    end
    checks++;
    if ({rdy4, done4, busy4, eq4, gt4, lt4} !== 6'b000100) begin
      errors++;
      $display("FAIL reset_dut4 got rdy/done/busy/eq/gt/lt=%b want 000100",
               {rdy4, done4, busy4, eq4, gt4, lt4});
    end
    rst = 1'b0;
    step();
  endtask

  task automatic test_single_gt();
    int acc, lat; bit early, ok; logic [2:0] res, exp;
    exp_q.push_back(model(32'hC6, 32'h33, 3'b100));
    run(1'b0, 32'hC6, 32'h33, 3'b100, 8'h00, 0, -1, -1, acc, early, ok, lat, res);
    checks++;
    if (!ok) begin errors++; $display("FAIL single_gt_run busy/ready got 0 want 1"); end
    checks++;
    if (lat !== 1) begin errors++; $display("FAIL single_gt_latency got %0d want 1", lat); end
    exp = exp_q.pop_front();
    checks++;
    if (res !== exp) begin errors++; $display("FAIL single_gt_result got %b want %b", res, exp); end
    step();
    checks++;
    if ({done_o, busy_o} !== 2'b00) begin
      errors++;
      $display("FAIL single_gt_pulse got done/busy=%b want 00", {done_o, busy_o});
    end
  endtask

  task automatic test_single_lt_hold();
    int acc, lat; bit early, ok; logic [2:0] res, exp;
    exp_q.push_back(model(32'hC6, 32'hF3, 3'b100));
    run(1'b0, 32'hC6, 32'hF3, 3'b100, 8'h00, 0, -1, -1, acc, early, ok, lat, res);
    exp = exp_q.pop_front();
    checks++;
    if (lat !== 1 || res !== exp) begin
      errors++;
      $display("FAIL lt_run1 got lat=%0d res=%b want lat=1 res=%b", lat, res, exp);
    end
    for (int i = 0; i < 4; i++) step();
    checks++;
    if ({done_o, res_o} !== {1'b0, exp}) begin
      errors++;
      $display("FAIL lt_hold got done/res=%b want %b", {done_o, res_o}, {1'b0, exp});
    end
    exp_q.push_back(model(32'hC6, 32'hEF, 3'b100));
    run(1'b0, 32'hC6, 32'hEF, 3'b100, 8'h00, 0, -1, -1, acc, early, ok, lat, res);
    exp = exp_q.pop_front();
    checks++;
    if (lat !== 1 || res !== exp) begin
      errors++;
      $display("FAIL lt_run2 got lat=%0d res=%b want lat=1 res=%b", lat, res, exp);
    end
    step();
  endtask

  task automatic test_first_diff();
    int acc, lat; bit early, ok; logic [2:0] res, exp;
    exp_q.push_back(model(32'h12C60000, 32'h12C5FFFF, 3'b100));
    run(1'b1, 32'h12C60000, 32'h12C5FFFF, 3'b100, 8'h00, 0, -1, -1, acc, early, ok, lat, res);
    exp = exp_q.pop_front();
    checks++;
    if (acc !== 4) begin errors++; $display("FAIL first_diff_accepts got %0d want 4", acc); end
    checks++;
    if (lat !== 1 || early) begin
      errors++;
      $display("FAIL first_diff_done got lat=%0d early=%0d want lat=1 early=0", lat, early);
    end
    checks++;
    if (res !== exp) begin errors++; $display("FAIL first_diff_result got %b want %b", res, exp); end
    step();
  endtask

  task automatic test_cascade_tie();
    logic [2:0] cascs[3] = '{3'b010, 3'b001, 3'b100};
    int acc, lat; bit early, ok; logic [2:0] res, exp;
    foreach (cascs[k]) begin
      exp_q.push_back(model(32'hC6C6C6C6, 32'hC6C6C6C6, cascs[k]));
      run(1'b1, 32'hC6C6C6C6, 32'hC6C6C6C6, cascs[k], 8'h00, 0, -1, -1,
          acc, early, ok, lat, res);
      exp = exp_q.pop_front();
      checks++;
      if (lat !== 1) begin
        errors++;
        $display("FAIL tie_latency casc=%b got %0d want 1", cascs[k], lat);
      end
      checks++;
      if (res !== exp) begin
        errors++;
        $display("FAIL tie_result casc=%b got %b want %b", cascs[k], res, exp);
      end
      step();
    end
  endtask

  task automatic test_stall_restart();
    int acc, lat; bit early, ok; logic [2:0] res, exp;
    exp_q.push_back(model(32'h00000001, 32'h00000000, 3'b001));
    // valid pattern 1,0,0,1,1,0,1 with start pulsed on the third offered cycle
    run(1'b1, 32'h00000001, 32'h00000000, 3'b001, 8'h59, 7, 2, -1, acc, early, ok, lat, res);
    exp = exp_q.pop_front();
    checks++;
    if (acc !== 4) begin errors++; $display("FAIL stall_accepts got %0d want 4", acc); end
    checks++;
    if (early) begin errors++; $display("FAIL stall_early_done got 1 want 0"); end
    checks++;
    if (lat !== 1) begin errors++; $display("FAIL stall_latency got %0d want 1", lat); end
    checks++;
    if (res !== exp) begin errors++; $display("FAIL stall_result got %b want %b", res, exp); end
    step();
    step();
    checks++;
    if ({busy_o, done_o} !== 2'b00) begin
      errors++;
      $display("FAIL stall_no_restart got busy/done=%b want 00", {busy_o, done_o});
    end
  endtask

  task automatic test_reset_mid_run();
    int acc, lat, seen; bit early, ok; logic [2:0] res, exp;
    exp_q.push_back(model(32'h01000000, 32'h02000000, 3'b100));
    run(1'b1, 32'h01000000, 32'h02000000, 3'b100, 8'h00, 0, -1, 2, acc, early, ok, lat, res);
    void'(exp_q.pop_front());
    checks++;
    if (acc !== 2) begin errors++; $display("FAIL rst_mid_accepts got %0d want 2", acc); end
    rst = 1'b1;
    step();
    checks++;
    if ({rdy, busy_o, done_o, res_o} !== 6'b000100) begin
      errors++;
      $display("FAIL rst_mid_state got rdy/busy/done/res=%b want 000100",
               {rdy, busy_o, done_o, res_o});
    end
    rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      if (done_o) seen++;
      step();
    end
    checks++;
    if (seen !== 0) begin errors++; $display("FAIL rst_mid_done_pulses got %0d want 0", seen); end
    exp_q.push_back(model(32'h12345678, 32'h12345679, 3'b010));
    run(1'b1, 32'h12345678, 32'h12345679, 3'b010, 8'h00, 0, -1, -1, acc, early, ok, lat, res);
    exp = exp_q.pop_front();
    checks++;
    if (lat !== 1 || res !== exp) begin
      errors++;
      $display("FAIL rst_fresh_run got lat=%0d res=%b want lat=1 res=%b", lat, res, exp);
    end
    step();
  endtask

  initial begin
    test_reset();
    test_single_gt();
    test_single_lt_hold();
    test_first_diff();
    test_cascade_tie();
    test_stall_restart();
    test_reset_mid_run();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
